// File: rtl/divider_constant_time.sv
// Restoring divider: exactly one subtract-and-select step per RUN cycle.
// Every operation takes the same number of cycles, whatever the operands are.
module divider_constant_time #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             quotientDone,
  output logic             divByZero,
  output logic             busy,
  output logic [1:0]       state_dbg
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] work;     // dividend bits shift out at the top, quotient bits shift in at the bottom
  logic [WIDTH-1:0] dvs_r;
  logic [WIDTH:0]   rem_r;
  logic [CW-1:0]    count;
  logic [WIDTH+1:0] shifted;
  logic [WIDTH+1:0] trial;

  // Subtraction is always evaluated; the sign bit only drives the select.
  always_comb begin
    shifted = {rem_r, work[WIDTH-1]};
    trial   = shifted - {2'b00, dvs_r};
  end

  assign state_dbg = state;

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= S_IDLE;
      work         <= '0;
      dvs_r        <= '0;
      rem_r        <= '0;
      count        <= '0;
      quotient     <= '0;
      remainder    <= '0;
      quotientDone <= 1'b0;
      divByZero    <= 1'b0;
      busy         <= 1'b0;
    end else begin
      quotientDone <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            work  <= dividend;
            dvs_r <= divisor;
            rem_r <= '0;
            count <= CW'(WIDTH - 1);
            busy  <= 1'b1;
            state <= S_RUN;
          end
        end
        S_RUN: begin
          rem_r <= trial[WIDTH+1] ? shifted[WIDTH:0] : trial[WIDTH:0];
          work  <= {work[WIDTH-2:0], ~trial[WIDTH+1]};
          count <= count - 1'b1;
          if (count == '0) state <= S_DONE;
        end
        S_DONE: begin
          quotient     <= work;
          remainder    <= rem_r[WIDTH-1:0];
          divByZero    <= (dvs_r == '0);
          quotientDone <= 1'b1;
          busy         <= 1'b0;
          state        <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_divider_constant_time.sv
// Bench for divider_constant_time at WIDTH=4: directed table, hand-written
// corner sequences, exhaustive sweep and random operands against an arithmetic model.
module tb_divider_constant_time;

  localparam int W   = 4;
  localparam int LAT = W + 1;

  logic         clk = 1'b0;
  logic         rst;
  logic         start, start1;
  logic [W-1:0] dividend, divisor, dividend1, divisor1;
  logic [W-1:0] quotient, remainder, quotient1, remainder1;
  logic         quotientDone, divByZero, busy;
  logic         quotientDone1, divByZero1, busy1;
  logic [1:0]   state_dbg, state_dbg1;

  int checks = 0;
  int errors = 0;

  divider_constant_time #(.WIDTH(W)) u0 (
    .clk(clk), .rst(rst), .start(start), .dividend(dividend), .divisor(divisor),
    .quotient(quotient), .remainder(remainder), .quotientDone(quotientDone),
    .divByZero(divByZero), .busy(busy), .state_dbg(state_dbg)
  );

  divider_constant_time #(.WIDTH(W)) u1 (
    .clk(clk), .rst(rst), .start(start1), .dividend(dividend1), .divisor(divisor1),
    .quotient(quotient1), .remainder(remainder1), .quotientDone(quotientDone1),
    .divByZero(divByZero1), .busy(busy1), .state_dbg(state_dbg1)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // reference model
  typedef struct {
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         z;
  } res_t;

  function automatic res_t model(input int a, input int b);
    res_t m;
    if (b == 0) begin
      m.q = '1;
      m.r = W'(a);
      m.z = 1'b1;
    end else begin
      m.q = W'(a / b);
      m.r = W'(a % b);
      m.z = 1'b0;
    end
    return m;
  endfunction

  // scoreboard: expected results queued per operation, popped on done
  logic [3*W-1:0] exp_q[$];

  // driver: start an op on u0, scramble operands while in flight, wait for done
  task automatic run_op(input int a, input int b, input string name);
    res_t m;
    int   lat;
    logic [3*W-1:0] e;
    m = model(a, b);
    exp_q.push_back({m.q, m.r, {(W-1){1'b0}}, m.z});
    @(negedge clk);
    dividend = W'(a);
    divisor  = W'(b);
    start    = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    lat = 0;
    while (lat < 20) begin
      dividend = W'($urandom);
      divisor  = W'($urandom);
      @(posedge clk);
      lat++;
      #1;
      if (quotientDone) break;
    end
    e = exp_q.pop_front();
    chk({name, " latency"}, lat, LAT);
    checks++;
    if ({quotient, remainder, {(W-1){1'b0}}, divByZero} != e) begin
      errors++;
      $display("FAIL %s result: got q=%0d r=%0d z=%0d expected q=%0d r=%0d z=%0d",
               name, quotient, remainder, divByZero, e[3*W-1 -: W], e[2*W-1 -: W], e[0]);
    end
    @(posedge clk);
    #1;
    if (quotientDone) begin
      checks++;
      errors++;
      $display("FAIL %s pulse width: got 2+ cycles expected 1", name);
    end
  endtask

  typedef struct {
    int a;
    int b;
    int q;
    int r;
    int z;
  } vec_t;

  vec_t vecs[4];

  initial begin
    int   mism, seen, lat;
    res_t m;

    rst = 1'b0; start = 1'b0; start1 = 1'b0;
    dividend = '0; divisor = '0; dividend1 = '0; divisor1 = '0;
    vecs[0] = '{13, 4, 3, 1, 0};
    vecs[1] = '{15, 1, 15, 0, 0};
    vecs[2] = '{0, 7, 0, 0, 0};
    vecs[3] = '{9, 0, 15, 9, 1};

    do_reset();
    #1;
    chk("reset quotient", quotient, 0);
    chk("reset remainder", remainder, 0);
    chk("reset done", quotientDone, 0);
    chk("reset dbz", divByZero, 0);
    chk("reset busy", busy, 0);
    chk("reset state", state_dbg, 0);

    // directed table: explicit expectations, independent of the model
    for (int i = 0; i < 4; i++) begin
      run_op(vecs[i].a, vecs[i].b, $sformatf("vec%0d", i));
      chk($sformatf("vec%0d q", i), quotient, vecs[i].q);
      chk($sformatf("vec%0d r", i), remainder, vecs[i].r);
      chk($sformatf("vec%0d z", i), divByZero, vecs[i].z);
    end

    // two instances started together must finish together
    @(negedge clk);
    dividend = 4'd15; divisor = 4'd1; dividend1 = 4'd1; divisor1 = 4'd15;
    start = 1'b1; start1 = 1'b1;
    @(posedge clk);
    #1 start = 1'b0; start1 = 1'b0;
    mism = 0; seen = 0;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk);
      #1;
      if (quotientDone != quotientDone1) mism++;
      if (quotientDone && quotientDone1) begin
        seen++;
        chk("dual u0 q", quotient, 15);
        chk("dual u1 q", quotient1, 0);
        chk("dual u1 r", remainder1, 1);
      end
    end
    chk("dual done mismatches", mism, 0);
    chk("dual done seen", seen, 1);

    // start pulses during RUN and DONE are ignored
    @(negedge clk);
    dividend = 4'd13; divisor = 4'd4; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    seen = 0; lat = 0;
    for (int c = 1; c <= 16; c++) begin
      if (c == 3 || c == 5) begin
        dividend = 4'd7; divisor = 4'd2; start = 1'b1;
      end
      @(posedge clk);
      #1 start = 1'b0;
      if (quotientDone) begin
        seen++;
        lat = c;
        chk("ignore q", quotient, 3);
        chk("ignore r", remainder, 1);
        chk("ignore busy after done", busy, 0);
      end
    end
    chk("ignore done count", seen, 1);
    chk("ignore latency", lat, LAT);
    chk("ignore busy idle", busy, 0);

    // reset in the third RUN cycle aborts the op
    @(negedge clk);
    dividend = 4'd13; divisor = 4'd4; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    chk("abort quotient", quotient, 0);
    chk("abort remainder", remainder, 0);
    chk("abort done", quotientDone, 0);
    chk("abort dbz", divByZero, 0);
    chk("abort busy", busy, 0);
    chk("abort state", state_dbg, 0);
    seen = 0;
    for (int c = 0; c < 8; c++) begin
      @(posedge clk);
      #1;
      if (quotientDone) seen++;
    end
    chk("abort no done", seen, 0);
    run_op(6, 3, "after abort");
    chk("after abort q", quotient, 2);
    chk("after abort r", remainder, 0);

    // exhaustive sweep against the model
    for (int a = 0; a < 16; a++)
      for (int b = 0; b < 16; b++)
        run_op(a, b, $sformatf("sweep %0d/%0d", a, b));

    // random operands; results must also hold while idle
    for (int i = 0; i < 40; i++) begin
      int a, b;
      a = $urandom_range(0, 15);
      b = $urandom_range(0, 15);
      run_op(a, b, $sformatf("rand %0d/%0d", a, b));
      m = model(a, b);
      repeat ($urandom_range(0, 3)) @(posedge clk);
      #1;
      chk("hold q", quotient, m.q);
      chk("hold r", remainder, m.r);
      chk("hold z", divByZero, m.z);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/divider_constant_time.md
DIVIDER_CONSTANT_TIME -- requirements
Module: divider_constant_time

Interface
REQ-001 The block SHALL have parameter WIDTH, default 4, the operand width in bits; legal values are 2 to 32.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-004 The block SHALL have port start, input, 1 bit: request a division; sampled only in IDLE.
REQ-005 The block SHALL have port dividend, input, WIDTH bits: unsigned numerator; captured on the edge that accepts start.
REQ-006 The block SHALL have port divisor, input, WIDTH bits: unsigned denominator; captured on the same edge as dividend.
REQ-007 The block SHALL have port quotient, output, WIDTH bits: registered result.
REQ-008 The block SHALL have port remainder, output, WIDTH bits: registered result.
REQ-009 The block SHALL have port quotientDone, output, 1 bit: one-cycle pulse marking valid results.
REQ-010 The block SHALL have port divByZero, output, 1 bit: registered flag, valid with the results.
REQ-011 The block SHALL have port busy, output, 1 bit: high in RUN and DONE.

Function
REQ-012 The block SHALL implement a 3-state FSM: IDLE, RUN, DONE.
REQ-013 In IDLE with start=1, the block SHALL latch the operands, clear the partial remainder (WIDTH+1 bits), load the step counter with WIDTH-1, and enter RUN.
REQ-014 In IDLE with start=0, the block SHALL remain in IDLE and hold all outputs.
REQ-015 In each RUN cycle, the block SHALL perform one restoring step, MSB first: shift the remainder left, bringing in the next dividend bit; compute trial = remainder - divisor; if trial is non-negative, keep trial and set the quotient bit to 1, otherwise keep the remainder and set the bit to 0.
REQ-016 Every RUN step SHALL compute the subtraction and select the result with a mux, with no data-dependent early exit or skipped steps.
REQ-017 The block SHALL execute RUN for exactly WIDTH cycles, decrementing the counter each cycle, and SHALL move to DONE after the step taken with the counter at 0.
REQ-018 In DONE, the block SHALL drive quotientDone=1 for exactly one cycle, present the final quotient, remainder and divByZero, then return to IDLE unconditionally.
REQ-019 Latency: with start accepted at edge N, quotientDone SHALL be high during the cycle after edge N+WIDTH+1, independent of operand values (including zero operands and a zero divisor).
REQ-020 quotient, remainder and divByZero SHALL hold their values after DONE until the DONE of the next operation.
REQ-021 start SHALL be ignored in RUN and DONE; it is not queued. start asserted during the DONE cycle SHALL have no effect.
REQ-022 Divisor=0: the block SHALL run the same WIDTH steps; the result SHALL be quotient = all ones and remainder = dividend; divByZero SHALL be 1.
REQ-023 When divisor is non-zero, divByZero SHALL be 0.
REQ-024 Changes on dividend or divisor after acceptance SHALL NOT affect the result in flight.
REQ-025 Arithmetic SHALL be unsigned, with no overflow possible; remainder < divisor SHALL hold whenever divisor is non-zero.

Reset
REQ-026 rst=1 at an edge SHALL force IDLE and clear all internal state.
REQ-027 rst=1 at an edge SHALL set quotient, remainder, quotientDone, divByZero and busy to 0.
REQ-028 rst SHALL take priority over start.
REQ-029 rst asserted mid-RUN or in DONE SHALL abort the operation; no quotientDone pulse SHALL follow.
REQ-030 The first start accepted after rst deasserts SHALL behave as from power-up.

Verification (WIDTH=4)
REQ-031 The bench SHALL drive dividend=13, divisor=4, start pulsed at edge N -> quotientDone high only after edge N+5; quotient=3, remainder=1, divByZero=0.
REQ-032 The bench SHALL drive 15/1, 0/7 and 9/0 in sequence -> (15,0,0), (0,0,0) and (15,9,1); each operation's done comes WIDTH+1 edges after its start.
REQ-033 The bench SHALL run two instances started on the same edge with 15/1 and 1/15 -> quotientDone asserts on the same cycle in both; the mismatch check never fires.
REQ-034 The bench SHALL accept 13/4, then pulse start with 7/2 during RUN and during DONE -> a single result 3 r 1; no second operation; busy low after DONE.
REQ-035 The bench SHALL accept 13/4, then assert rst at the third RUN cycle -> all outputs 0 and IDLE next cycle; no done pulse; a following 6/3 yields 2 r 0 at normal latency.
REQ-036 The bench SHALL run an exhaustive sweep of all 256 operand pairs -> each result matches the integer / and % operators (zero-divisor rule for divisor=0); latency is always 5.
